// File: rtl/pupil_centroid_pkg.sv
// Shared definitions for pupil_centroid: FSM states, width derivations and default threshold.
package pupil_centroid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        POST = 2'd2
    } state_t;

    localparam int DEFAULT_MIN_COUNT = 16;

    // Pixel counter must hold a full frame of candidates.
    function automatic int cnt_width(input int hactive, input int vactive);
        return $clog2(hactive * vactive + 1);
    endfunction

    function automatic int sum_width(input int addr_width, input int cnt_w);
        return addr_width + cnt_w;
    endfunction

endpackage

// File: rtl/pupil_centroid_serial_divider.sv
// Restoring serial divider, one quotient bit per cycle (MSB first), start/done handshake.
// DIVIDEND_W must equal DIVISOR_W + QUOT_W; the upper dividend bits seed the remainder.
module serial_divider #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 19,
    parameter int QUOT_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic                  done
);

    localparam int STEP_W = $clog2(QUOT_W + 1);

    logic [DIVISOR_W-1:0] rem;
    logic [DIVISOR_W-1:0] rem_next;
    logic [DIVISOR_W-1:0] divisor_r;
    logic [QUOT_W-1:0]    low;
    logic [QUOT_W-1:0]    quot;
    logic [STEP_W-1:0]    step;
    logic                 running;
    logic [DIVISOR_W:0]   trial;
    logic                 fits;

    // quotient is the value after the current step, so it is final while done is high
    always_comb begin
        trial    = {rem, low[QUOT_W-1]};
        fits     = trial >= {1'b0, divisor_r};
        rem_next = fits ? (trial[DIVISOR_W-1:0] - divisor_r) : trial[DIVISOR_W-1:0];
        quotient = {quot[QUOT_W-2:0], fits};
        done     = running && (step == STEP_W'(QUOT_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            divisor_r <= '0;
            low       <= '0;
            quot      <= '0;
            step      <= '0;
            running   <= 1'b0;
        end else if (start) begin
            rem       <= dividend[DIVIDEND_W-1:QUOT_W];
            low       <= dividend[QUOT_W-1:0];
            divisor_r <= divisor;
            quot      <= '0;
            step      <= '0;
            running   <= 1'b1;
        end else if (running) begin
            rem  <= rem_next;
            low  <= {low[QUOT_W-2:0], 1'b0};
            quot <= quotient;
            step <= step + STEP_W'(1);
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/pupil_centroid.sv
// Pupil centroid: accumulates dark-pixel coordinate sums per frame and divides at frame end.
// Optional region-of-interest gating is enabled by defining PUPIL_CENTROID_ROI_EN.
module pupil_centroid
    import pupil_centroid_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = 640,
    parameter int VACTIVE    = 480,
    parameter int MIN_COUNT  = DEFAULT_MIN_COUNT
) (
    input  logic                  VCLK,
    input  logic                  RST,
    input  logic                  iVSYNC,
    input  logic                  iDE,
    input  logic [ADDR_WIDTH-1:0] iH_ADDR,
    input  logic [ADDR_WIDTH-1:0] iV_ADDR,
    input  logic                  iPIX,
`ifdef PUPIL_CENTROID_ROI_EN
    input  logic [ADDR_WIDTH-1:0] iROI_X0,
    input  logic [ADDR_WIDTH-1:0] iROI_X1,
    input  logic [ADDR_WIDTH-1:0] iROI_Y0,
    input  logic [ADDR_WIDTH-1:0] iROI_Y1,
`endif
    output logic [ADDR_WIDTH-1:0] oPOINT_X,
    output logic [ADDR_WIDTH-1:0] oPOINT_Y,
    output logic                  oVALID,
    output logic                  oLOST,
    output logic                  oBUSY
);

    localparam int CNT_W = cnt_width(HACTIVE, VACTIVE);
    localparam int SUM_W = sum_width(ADDR_WIDTH, CNT_W);

    state_t                state;
    state_t                state_next;
    logic                  vsync_d;
    logic                  frame_end;
    logic                  in_roi;
    logic                  hit;
    logic                  enough;
    logic                  start;
    logic [SUM_W-1:0]      sum_x;
    logic [SUM_W-1:0]      sum_y;
    logic [CNT_W-1:0]      cnt;
    logic [SUM_W-1:0]      sum_x_next;
    logic [SUM_W-1:0]      sum_y_next;
    logic [CNT_W-1:0]      cnt_next;
    logic [ADDR_WIDTH-1:0] quot_x;
    logic [ADDR_WIDTH-1:0] quot_y;
    logic                  done_x;
    logic                  done_y;

`ifdef PUPIL_CENTROID_ROI_EN
    assign in_roi = (iH_ADDR >= iROI_X0) && (iH_ADDR <= iROI_X1) &&
                    (iV_ADDR >= iROI_Y0) && (iV_ADDR <= iROI_Y1);
`else
    assign in_roi = 1'b1;
`endif

    // The *_next values include a pixel arriving in the frame-end cycle itself
    always_comb begin
        frame_end  = iVSYNC & ~vsync_d;
        hit        = iDE & iPIX & in_roi;
        sum_x_next = sum_x + (hit ? SUM_W'(iH_ADDR) : '0);
        sum_y_next = sum_y + (hit ? SUM_W'(iV_ADDR) : '0);
        cnt_next   = cnt + CNT_W'(hit);
        enough     = cnt_next >= CNT_W'(MIN_COUNT);
        start      = frame_end && (state == IDLE) && enough;
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            vsync_d <= 1'b0;
            sum_x   <= '0;
            sum_y   <= '0;
            cnt     <= '0;
        end else begin
            vsync_d <= iVSYNC;
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
            end else begin
                sum_x <= sum_x_next;
                sum_y <= sum_y_next;
                cnt   <= cnt_next;
            end
        end
    end

    serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (ADDR_WIDTH)
    ) div_x (
        .clk      (VCLK),
        .rst      (RST),
        .start    (start),
        .dividend (sum_x_next),
        .divisor  (cnt_next),
        .quotient (quot_x),
        .done     (done_x)
    );

    serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (ADDR_WIDTH)
    ) div_y (
        .clk      (VCLK),
        .rst      (RST),
        .start    (start),
        .dividend (sum_y_next),
        .divisor  (cnt_next),
        .quotient (quot_y),
        .done     (done_y)
    );

    always_ff @(posedge VCLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DIV;
            DIV:     if (done_x && done_y) state_next = POST;
            POST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers load on the edge entering POST, so they change only in the oVALID cycle
    always_ff @(posedge VCLK) begin
        if (RST) begin
            oPOINT_X <= ADDR_WIDTH'(HACTIVE / 2);
            oPOINT_Y <= ADDR_WIDTH'(VACTIVE / 2);
            oVALID   <= 1'b0;
            oLOST    <= 1'b1;
        end else begin
            oVALID <= 1'b0;
            if (state == DIV && done_x && done_y) begin
                oPOINT_X <= quot_x;
                oPOINT_Y <= quot_y;
                oLOST    <= 1'b0;
                oVALID   <= 1'b1;
            end else if (frame_end && state == IDLE && !enough) begin
                oLOST  <= 1'b1;
                oVALID <= 1'b1;
            end
        end
    end

    assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_pupil_centroid.sv
// Self-checking bench for pupil_centroid: table of rectangular pixel frames plus hand-written corner cases.
// ROI checks are compiled in when PUPIL_CENTROID_ROI_EN is defined.
module tb_pupil_centroid;

    localparam int AW = 11;

    logic          VCLK = 1'b0;
    logic          RST;
    logic          iVSYNC;
    logic          iDE;
    logic [AW-1:0] iH_ADDR;
    logic [AW-1:0] iV_ADDR;
    logic          iPIX;
`ifdef PUPIL_CENTROID_ROI_EN
    logic [AW-1:0] iROI_X0;
    logic [AW-1:0] iROI_X1;
    logic [AW-1:0] iROI_Y0;
    logic [AW-1:0] iROI_Y1;
`endif
    logic [AW-1:0] oPOINT_X;
    logic [AW-1:0] oPOINT_Y;
    logic          oVALID;
    logic          oLOST;
    logic          oBUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x0;
        int w;
        int y0;
        int h;
        int ystep;
        bit drop;
        int expLat;
        int expX;
        int expY;
        int expLost;
    } frame_t;

    frame_t vecs[6];

    int lat, pulses, px, py, lost, busy1;

    pupil_centroid dut (
        .VCLK     (VCLK),
        .RST      (RST),
        .iVSYNC   (iVSYNC),
        .iDE      (iDE),
        .iH_ADDR  (iH_ADDR),
        .iV_ADDR  (iV_ADDR),
        .iPIX     (iPIX),
`ifdef PUPIL_CENTROID_ROI_EN
        .iROI_X0  (iROI_X0),
        .iROI_X1  (iROI_X1),
        .iROI_Y0  (iROI_Y0),
        .iROI_Y1  (iROI_Y1),
`endif
        .oPOINT_X (oPOINT_X),
        .oPOINT_Y (oPOINT_Y),
        .oVALID   (oVALID),
        .oLOST    (oLOST),
        .oBUSY    (oBUSY)
    );

    always #5 VCLK = ~VCLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic drivePixel(input int x, input int y);
        iDE     = 1'b1;
        iPIX    = 1'b1;
        iH_ADDR = AW'(x);
        iV_ADDR = AW'(y);
        tick();
    endtask

    task automatic applyStimulus(input frame_t f);
        for (int r = 0; r < f.h; r++) begin
            for (int c = 0; c < f.w; c++) begin
                if (!(f.drop && r == f.h - 1 && c == f.w - 1))
                    drivePixel(f.x0 + c, f.y0 + r * f.ystep);
            end
        end
        iDE  = 1'b0;
        iPIX = 1'b0;
        tick();
        tick();
    endtask

    // Raise VSYNC (cycle T), optionally with a pixel in T, and watch 20 cycles for oVALID
    task automatic frameEnd(input int hold, input bit pixOn, input int x, input int y);
        lat    = -1;
        pulses = 0;
        px     = -1;
        py     = -1;
        lost   = -1;
        busy1  = -1;
        iDE     = pixOn;
        iPIX    = pixOn;
        iH_ADDR = AW'(x);
        iV_ADDR = AW'(y);
        iVSYNC  = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) begin
                iDE   = 1'b0;
                iPIX  = 1'b0;
                busy1 = int'(oBUSY);
            end
            if (n == hold)
                iVSYNC = 1'b0;
            if (oVALID) begin
                pulses++;
                if (lat < 0) begin
                    lat  = n;
                    px   = int'(oPOINT_X);
                    py   = int'(oPOINT_Y);
                    lost = int'(oLOST);
                end
            end
        end
        iVSYNC = 1'b0;
        tick();
        tick();
    endtask

    task automatic checkFrame(input string tag, input int eLat, input int eX, input int eY, input int eLost);
        checkOutput({tag, " latency"}, lat, eLat);
        checkOutput({tag, " pulses"}, pulses, 1);
        checkOutput({tag, " point_x"}, px, eX);
        checkOutput({tag, " point_y"}, py, eY);
        checkOutput({tag, " lost"}, lost, eLost);
        checkOutput({tag, " busy_t1"}, busy1, (eLost != 0) ? 0 : 1);
    endtask

    initial begin
        int cnt;
        int firstLat;
        int vx;
        int vy;
        frame_t blk;
        frame_t blk2;

        vecs[0] = '{x0:100, w:4,   y0:200, h:4,  ystep:1,   drop:1'b1, expLat:1,  expX:320, expY:240, expLost:1};
        vecs[1] = '{x0:100, w:4,   y0:200, h:4,  ystep:1,   drop:1'b0, expLat:12, expX:101, expY:201, expLost:0};
        vecs[2] = '{x0:0,   w:640, y0:0,   h:2,  ystep:479, drop:1'b0, expLat:12, expX:319, expY:239, expLost:0};
        vecs[3] = '{x0:5,   w:1,   y0:10,  h:16, ystep:1,   drop:1'b0, expLat:12, expX:5,   expY:17,  expLost:0};
        vecs[4] = '{x0:0,   w:3,   y0:0,   h:5,  ystep:1,   drop:1'b0, expLat:1,  expX:5,   expY:17,  expLost:1};
        vecs[5] = '{x0:7,   w:8,   y0:3,   h:2,  ystep:5,   drop:1'b0, expLat:12, expX:10,  expY:5,   expLost:0};
        blk  = vecs[1];
        blk2 = '{x0:20, w:4, y0:40, h:4, ystep:1, drop:1'b0, expLat:12, expX:21, expY:41, expLost:0};

        RST     = 1'b1;
        iVSYNC  = 1'b0;
        iDE     = 1'b0;
        iPIX    = 1'b0;
        iH_ADDR = '0;
        iV_ADDR = '0;
`ifdef PUPIL_CENTROID_ROI_EN
        iROI_X0 = '0;
        iROI_X1 = '1;
        iROI_Y0 = '0;
        iROI_Y1 = '1;
`endif
        repeat (3) tick();
        RST = 1'b0;
        tick();

        checkOutput("reset point_x", int'(oPOINT_X), 320);
        checkOutput("reset point_y", int'(oPOINT_Y), 240);
        checkOutput("reset valid", int'(oVALID), 0);
        checkOutput("reset lost", int'(oLOST), 1);
        checkOutput("reset busy", int'(oBUSY), 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            frameEnd(2, 1'b0, 0, 0);
            checkFrame($sformatf("vec%0d", i), vecs[i].expLat, vecs[i].expX, vecs[i].expY, vecs[i].expLost);
        end

        // 16th pixel arrives in the frame-end cycle itself
        for (int i = 0; i < 15; i++) drivePixel(50, 60);
        iDE  = 1'b0;
        iPIX = 1'b0;
        tick();
        frameEnd(2, 1'b1, 66, 76);
        checkFrame("pixel_in_T", 12, 51, 61, 0);

        // Pixels with iDE low never count; VSYNC held high is a single frame end
        for (int i = 0; i < 20; i++) begin
            iDE     = 1'b0;
            iPIX    = 1'b1;
            iH_ADDR = AW'(i);
            iV_ADDR = AW'(i);
            tick();
        end
        iPIX = 1'b0;
        frameEnd(15, 1'b0, 0, 0);
        checkFrame("de_low", 1, 51, 61, 1);

        // Second frame end during DIV: discarded, no extra oVALID, accumulators cleared
        applyStimulus(blk);
        iVSYNC   = 1'b1;
        cnt      = 0;
        firstLat = -1;
        vx       = -1;
        vy       = -1;
        for (int n = 1; n <= 25; n++) begin
            tick();
            if (oVALID) begin
                cnt++;
                if (firstLat < 0) begin
                    firstLat = n;
                    vx = int'(oPOINT_X);
                    vy = int'(oPOINT_Y);
                end
            end
            iDE  = 1'b0;
            iPIX = 1'b0;
            if (n == 1 || n == 12) iVSYNC = 1'b0;
            if (n >= 2 && n <= 9) begin
                iDE     = 1'b1;
                iPIX    = 1'b1;
                iH_ADDR = AW'(300);
                iV_ADDR = AW'(300);
            end
            if (n == 10) iVSYNC = 1'b1;
        end
        checkOutput("vsync_in_div pulses", cnt, 1);
        checkOutput("vsync_in_div latency", firstLat, 12);
        checkOutput("vsync_in_div point_x", vx, 101);
        checkOutput("vsync_in_div point_y", vy, 201);
        applyStimulus(blk2);
        frameEnd(2, 1'b0, 0, 0);
        checkFrame("after_discard", 12, 21, 41, 0);

        // Reset in DIV cycle 5 aborts the division
        applyStimulus(blk);
        iVSYNC = 1'b1;
        cnt    = 0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            iVSYNC = 1'b0;
            if (oVALID) cnt++;
        end
        checkOutput("div busy before reset", int'(oBUSY), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort point_x", int'(oPOINT_X), 320);
        checkOutput("abort point_y", int'(oPOINT_Y), 240);
        checkOutput("abort lost", int'(oLOST), 1);
        checkOutput("abort busy", int'(oBUSY), 0);
        for (int n = 0; n < 15; n++) begin
            if (oVALID) cnt++;
            tick();
        end
        checkOutput("abort valid pulses", cnt, 0);

`ifdef PUPIL_CENTROID_ROI_EN
        iROI_X0 = AW'(0);
        iROI_X1 = AW'(99);
        iROI_Y0 = AW'(0);
        iROI_Y1 = '1;
        applyStimulus(blk);
        applyStimulus(blk2);
        frameEnd(2, 1'b0, 0, 0);
        checkFrame("roi", 12, 21, 41, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pupil_centroid.md
# pupil_centroid

Computes the pupil position for each camera frame as the centroid of binarized dark pixels. It accumulates X/Y coordinate sums and a pixel count while the frame streams through the pixel pipeline. At frame end it divides the sums by the count using a serial divider. It sits directly upstream of the VGA output stage and drives that stage's `iPOINT_X`/`iPOINT_Y` cursor inputs.

## Interface
- `ADDR_WIDTH`, 11, coordinate width.
- `HACTIVE`, 640, active pixels per line.
- `VACTIVE`, 480, active lines per frame.
- `MIN_COUNT`, 16, minimum pixel count for a valid centroid.
- `VCLK` input 1: pixel clock; all logic is on its rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `iVSYNC` input 1: vertical sync, active-high; its rising edge marks frame end.
- `iDE` input 1: active-video enable.
- `iH_ADDR` input ADDR_WIDTH: current pixel X.
- `iV_ADDR` input ADDR_WIDTH: current pixel Y.
- `iPIX` input 1: binarized pixel, 1 = pupil candidate.
- `oPOINT_X` output ADDR_WIDTH: centroid X.
- `oPOINT_Y` output ADDR_WIDTH: centroid Y.
- `oVALID` output 1: one-cycle pulse when a new frame result is posted.
- `oLOST` output 1: the last frame had fewer than MIN_COUNT pixels.
- `oBUSY` output 1: divider running.

## Operation
- Widths:
  - CNT_W = clog2(HACTIVE*VACTIVE+1) (19 by default).
  - SUM_W = ADDR_WIDTH+CNT_W (30 by default).
  - No overflow is possible.
- Accumulate when `iDE & iPIX`:
  - sum_x += iH_ADDR
  - sum_y += iV_ADDR
  - cnt += 1
- Frame end is detected on cycle T, when `iVSYNC & ~vsync_d` (vsync_d is `iVSYNC` registered one cycle).
- At the edge closing T:
  - sum_x, sum_y and cnt are latched into the divider operand registers.
  - The accumulators are cleared.
  - A pixel qualifying in cycle T is included in the latched values.
- FSM states: IDLE, DIV, POST.
  - IDLE → DIV on frame end with cnt ≥ MIN_COUNT.
  - IDLE stays IDLE on frame end with cnt < MIN_COUNT:
    - oVALID=1 and oLOST=1 in cycle T+1.
    - oPOINT_X/Y are held at their previous values.
  - DIV runs for ADDR_WIDTH cycles, then goes to POST.
  - POST lasts one cycle:
    - oPOINT_X/Y are loaded with the quotients, oLOST=0 and oVALID=1.
    - Returns to IDLE.
- Division is restoring, one quotient bit per cycle, X and Y in parallel, shared divisor cnt.
  - Remainder initialised to sum>>ADDR_WIDTH; this is always < cnt because every coordinate < 2^ADDR_WIDTH.
  - One low dividend bit is shifted in per cycle, MSB first.
  - The quotient is truncated (floor). The remainder is discarded.
- Frame end while in DIV/POST:
  - The new frame's sums are discarded and the accumulators are cleared.
  - The running division completes unaffected.
  - No extra oVALID is generated.
- oBUSY=1 in DIV and POST.

## Timing
- Reset values:
  - oPOINT_X=HACTIVE/2 (320), oPOINT_Y=VACTIVE/2 (240).
  - oVALID=0, oLOST=1, oBUSY=0.
  - Accumulators, vsync_d and FSM (IDLE) cleared.
- Latency, valid frame: oVALID is high in cycle T+ADDR_WIDTH+1 (T+12 by default).
- Latency, lost frame: oVALID is high in cycle T+1.
- oPOINT_X/Y change only in the oVALID cycle and then hold. The VGA output stage samples them at any time.
- RST during DIV aborts the division: no oVALID, all outputs go to their reset values next cycle.
- `iVSYNC` held high is one frame end only. It must fall and rise again before the next frame end.

## Configuration
- `PUPIL_CENTROID_ROI_EN`:
  - Defined: adds inputs `iROI_X0`, `iROI_X1`, `iROI_Y0`, `iROI_Y1` (ADDR_WIDTH each).
    - A pixel accumulates only if X0 ≤ iH_ADDR ≤ X1 and Y0 ≤ iV_ADDR ≤ Y1.
    - ROI inputs are sampled every cycle; software changes them only during vertical blank.
  - Undefined: ports absent, whole active frame accumulates.

## Structure
- Shared include/package holds:
  - FSM state encodings (IDLE, DIV, POST).
  - CNT_W/SUM_W derivation macros.
  - Default MIN_COUNT.
- Sub-module `SERIAL_DIVIDER`:
  - Parameters: dividend SUM_W, divisor CNT_W, quotient ADDR_WIDTH.
  - Handshake: start/done.
  - Instantiated twice (X, Y); the FSM stays in `pupil_centroid`.

## Test plan
- 4×4 block, x 100..103, y 200..203 (16 px), VSYNC rise at T → oVALID at T+12, oPOINT_X=101, oPOINT_Y=201, oLOST=0.
- Same block minus one pixel (15 px) → oVALID at T+1, oLOST=1, oPOINT held at 320/240 after reset.
- Full frame iPIX=1 → oPOINT_X=319, oPOINT_Y=239.
- iPIX=1 with iDE=0 throughout → count 0, oLOST=1; second VSYNC rise during DIV → exactly one oVALID, accumulators cleared.
- RST asserted in DIV cycle 5 → no oVALID, next cycle oPOINT=320/240, oLOST=1, oBUSY=0.
- With PUPIL_CENTROID_ROI_EN, ROI x 0..99 over the first test's block plus a 4×4 block at x 20..23, y 40..43 → oPOINT_X=21, oPOINT_Y=41.
